// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues sequential word fetches
// to a 1-cycle-latency instruction memory and buffers the responses in a
// small FIFO so decode back-pressure never loses an instruction. Handles
// redirect/flush from branch resolution.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   imem_req, imem_addr        fetch request and word-aligned address
//   imem_rdata, imem_rvalid    memory response, one cycle after request
//   redirect_valid/pc          flush and restart fetch at redirect_pc
//   instr_out, pc_out          head instruction and its PC (0 when empty)
//   valid_out, ready_in        valid/ready handshake with decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          drop;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [PW:0]   occupancy;
    logic          push;
    logic          pop;

    logic [31:0] fifo_pc    [DEPTH];
    logic [31:0] fifo_instr [DEPTH];

    logic [1:0] unused_pc_lsb;
    assign unused_pc_lsb = redirect_pc[1:0];

    // Buffered entries plus the outstanding request form the credit count,
    // so a response always has a free slot waiting for it.
    assign occupancy = count + {{PW{1'b0}}, inflight};
    assign imem_req  = !reset && !redirect_valid && (occupancy < FULL);
    assign imem_addr = fetch_pc;

    // Responses only belong to us when a request was outstanding; a
    // flush cycle discards the response landing in it.
    assign push = imem_rvalid && inflight && !drop && !redirect_valid;

    assign valid_out = (count != '0);
    assign pop       = valid_out && ready_in && !redirect_valid;
    assign instr_out = valid_out ? fifo_instr[head] : '0;
    assign pc_out    = valid_out ? fifo_pc[head]    : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= imem_req;
            drop     <= redirect_valid && inflight;
            if (imem_req) begin
                req_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[tail]    <= req_pc;
            fifo_instr[tail] <= imem_rdata;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && count == FULL))
            else $error("fetch_unit: push into full FIFO");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a 1-cycle memory
// model, table vectors, directed corner sequences and a queue-based model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_rvalid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in = 1'b0;

    int total = 0;
    int bad = 0;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .valid_out(valid_out),
        .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_val(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'hFFF3_0293;
            32'h8:   return 32'h0052_01B3;
            default: return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
        endcase
    endfunction

    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= imem_req ? imem_val(imem_addr) : 32'h0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: every issued-but-undelivered fetch sits in a queue
    // with its issue cycle. At most D may be outstanding; an entry becomes
    // visible two cycles after issue; redirect/reset empty the queue.
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] epc = RPC;
    int          cyc = 0;

    always @(negedge clk) begin : model
        bit er;
        bit hv;
        if (reset) begin
            chk("rst_req", {31'b0, imem_req}, 32'h0);
            chk("rst_valid", {31'b0, valid_out}, 32'h0);
            chk("rst_pc", pc_out, 32'h0);
            chk("rst_instr", instr_out, 32'h0);
            q.delete();
            epc = RPC;
        end else begin
            er = !redirect_valid && (q.size() < D);
            hv = 1'b0;
            if (q.size() != 0) hv = (q[0].cyc + 2 <= cyc);
            chk("m_req", {31'b0, imem_req}, {31'b0, er});
            if (er) chk("m_addr", imem_addr, epc);
            chk("m_valid", {31'b0, valid_out}, {31'b0, hv});
            if (hv) begin
                chk("m_pc", pc_out, q[0].pc);
                chk("m_instr", instr_out, imem_val(q[0].pc));
            end else begin
                chk("m_pc", pc_out, 32'h0);
                chk("m_instr", instr_out, 32'h0);
            end
            if (redirect_valid) begin
                q.delete();
                epc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (hv && ready_in) void'(q.pop_front());
                if (er) begin
                    q.push_back('{epc, cyc});
                    epc += 32'd4;
                end
            end
        end
        cyc++;
    end

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit rdy, input bit req,
                                input logic [31:0] addr, input bit v,
                                input logic [31:0] pc);
        vec_t r;
        r.rst  = rst;
        r.rdy  = rdy;
        r.req  = req;
        r.addr = addr;
        r.v    = v;
        r.pc   = v ? pc : 32'h0;
        r.ins  = v ? imem_val(pc) : 32'h0;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle;
        reset = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;
    endtask

    vec_t tbl [18];

    initial begin
        int n;
        logic [31:0] nxt;

        tbl[0]  = mk(1, 0, 0, 32'h0,  0, 32'h0);
        tbl[1]  = mk(0, 1, 1, 32'h0,  0, 32'h0);
        tbl[2]  = mk(0, 1, 1, 32'h4,  0, 32'h0);
        tbl[3]  = mk(0, 1, 1, 32'h8,  1, 32'h0);
        tbl[4]  = mk(0, 1, 1, 32'hC,  1, 32'h4);
        tbl[5]  = mk(0, 1, 1, 32'h10, 1, 32'h8);
        tbl[6]  = mk(1, 0, 0, 32'h0,  0, 32'h0);
        tbl[7]  = mk(0, 0, 1, 32'h0,  0, 32'h0);
        tbl[8]  = mk(0, 0, 1, 32'h4,  0, 32'h0);
        tbl[9]  = mk(0, 0, 1, 32'h8,  1, 32'h0);
        tbl[10] = mk(0, 0, 1, 32'hC,  1, 32'h0);
        tbl[11] = mk(0, 0, 0, 32'h0,  1, 32'h0);
        tbl[12] = mk(0, 0, 0, 32'h0,  1, 32'h0);
        tbl[13] = mk(0, 0, 0, 32'h0,  1, 32'h0);
        tbl[14] = mk(0, 1, 0, 32'h0,  1, 32'h0);
        tbl[15] = mk(0, 1, 1, 32'h10, 1, 32'h4);
        tbl[16] = mk(0, 1, 1, 32'h14, 1, 32'h8);
        tbl[17] = mk(0, 1, 1, 32'h18, 1, 32'hC);

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst;
            ready_in = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("t%0d_req", i), {31'b0, imem_req},
                {31'b0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("t%0d_addr", i), imem_addr,
                                tbl[i].addr);
            chk($sformatf("t%0d_valid", i), {31'b0, valid_out},
                {31'b0, tbl[i].v});
            chk($sformatf("t%0d_pc", i), pc_out, tbl[i].pc);
            chk($sformatf("t%0d_instr", i), instr_out, tbl[i].ins);
            tick();
        end

        // redirect with 2 buffered entries and one request in flight
        reset_cycle();
        ready_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("rd_r_valid", {31'b0, valid_out}, 32'h1);
        chk("rd_r_pc", pc_out, 32'h0);
        chk("rd_r_req", {31'b0, imem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_r1_req", {31'b0, imem_req}, 32'h1);
        chk("rd_r1_addr", imem_addr, 32'h100);
        chk("rd_r1_valid", {31'b0, valid_out}, 32'h0);
        tick();
        @(negedge clk);
        chk("rd_r2_valid", {31'b0, valid_out}, 32'h0);
        tick();
        @(negedge clk);
        chk("rd_r3_valid", {31'b0, valid_out}, 32'h1);
        chk("rd_r3_pc", pc_out, 32'h100);
        chk("rd_r3_instr", instr_out, imem_val(32'h100));
        tick();

        // reset mid-stream with 3 buffered entries
        reset_cycle();
        ready_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk("mr_pre_valid", {31'b0, valid_out}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_valid", {31'b0, valid_out}, 32'h0);
        chk("mr_pc", pc_out, 32'h0);
        chk("mr_instr", instr_out, 32'h0);
        chk("mr_req", {31'b0, imem_req}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        tick();
        reset = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        chk("mr_c0_addr", imem_addr, RPC);
        chk("mr_c0_valid", {31'b0, valid_out}, 32'h0);
        tick();
        @(negedge clk);
        chk("mr_c1_valid", {31'b0, valid_out}, 32'h0);
        tick();
        @(negedge clk);
        chk("mr_c2_valid", {31'b0, valid_out}, 32'h1);
        chk("mr_c2_pc", pc_out, RPC);
        tick();

        // ready toggling every cycle: in-order, exactly-once delivery
        reset_cycle();
        n = 0;
        nxt = RPC;
        for (int i = 0; i < 20; i++) begin
            ready_in = (i % 2 == 0);
            @(negedge clk);
            if (valid_out && ready_in) begin
                chk("tg_pc", pc_out, nxt);
                chk("tg_instr", instr_out, imem_val(nxt));
                nxt += 32'd4;
                n++;
            end
            tick();
        end
        chk("tg_count", n, 32'd9);

        // fetch PC wrap at the top of the address space
        reset_cycle();
        ready_in = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("wr_r_req", {31'b0, imem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wr_a0", imem_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("wr_a1", imem_addr, 32'h0);
        tick();
        @(negedge clk);
        chk("wr_pc0", pc_out, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("wr_pc1", pc_out, 32'h0);
        tick();

        // randomized traffic against the queue model
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            ready_in = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            tick();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;
        ready_in = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
